// File: rtl/ram64x18.sv
// ----------------------------------------------------------------------------
// ram64x18 -- 64 x 18-bit micro-SRAM model with two read ports and one write
// port, each with a selectable aspect ratio.
//
// Optional feature macro: RAM64X18_INIT_ZERO_EN
//   defined   : reset_n low also clears every row to zero (asynchronously)
//   undefined : reset leaves the array untouched
//
// Ports (names fixed by the surrounding FIFO controller):
//   clock, reset_n          single clock, asynchronous active-low reset
//   a_* / b_*               read ports: addr[9:0], blk[1:0], en, addr_en,
//                           addr_lat (1 = address bypass), dout_en,
//                           dout_lat (1 = output bypass), dout_srst_n,
//                           width[2:0], dout[17:0]
//   c_*                     write port: addr[9:0], din[17:0], wen, blk[1:0],
//                           en, width[2:0]
//   busy                    tied low
//
// Width codes: 000 x1, 001 x2, 010 x4, 011 x9, 100..111 x18.
// Row = addr[9:4]. Narrow modes (x1/x2/x4) work on the 16 data bits
// D = {row[16:9], row[7:0]}; row[17] and row[8] are only reachable in x9/x18.
// ----------------------------------------------------------------------------
module ram64x18 #(
    parameter int DEPTH_ROWS = 64,
    parameter int ROW_BITS   = 18
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [9:0]          a_addr,
    input  logic [1:0]          a_blk,
    input  logic                a_en,
    input  logic                a_addr_en,
    input  logic                a_addr_lat,
    input  logic                a_dout_en,
    input  logic                a_dout_lat,
    input  logic                a_dout_srst_n,
    input  logic [2:0]          a_width,
    output logic [ROW_BITS-1:0] a_dout,
    input  logic [9:0]          b_addr,
    input  logic [1:0]          b_blk,
    input  logic                b_en,
    input  logic                b_addr_en,
    input  logic                b_addr_lat,
    input  logic                b_dout_en,
    input  logic                b_dout_lat,
    input  logic                b_dout_srst_n,
    input  logic [2:0]          b_width,
    output logic [ROW_BITS-1:0] b_dout,
    input  logic [9:0]          c_addr,
    input  logic [ROW_BITS-1:0] c_din,
    input  logic                c_wen,
    input  logic [1:0]          c_blk,
    input  logic                c_en,
    input  logic [2:0]          c_width,
    output logic                busy
);

    logic [ROW_BITS-1:0] r_mem [DEPTH_ROWS];

    // Read the field selected by width/sub-address out of a row, right-justified.
    function automatic logic [17:0] f_extract(input logic [17:0] row,
                                              input logic [2:0]  width,
                                              input logic [3:0]  sub);
        logic [15:0] d;
        logic [17:0] res;
        d   = {row[16:9], row[7:0]};
        res = '0;
        case (width)
            3'b000:  res = {17'b0, d[sub]};
            3'b001:  res = {16'b0, d[{sub[3:1], 1'b0} +: 2]};
            3'b010:  res = {14'b0, d[{sub[3:2], 2'b00} +: 4]};
            3'b011:  res = {9'b0, (sub[3] ? row[17:9] : row[8:0])};
            default: res = row;
        endcase
        return res;
    endfunction

    // Return the row with only the addressed field replaced by din.
    function automatic logic [17:0] f_merge(input logic [17:0] row,
                                            input logic [2:0]  width,
                                            input logic [3:0]  sub,
                                            input logic [17:0] din);
        logic [15:0] d;
        logic [17:0] res;
        d   = {row[16:9], row[7:0]};
        res = row;
        case (width)
            3'b000:  d[sub] = din[0];
            3'b001:  d[{sub[3:1], 1'b0} +: 2] = din[1:0];
            3'b010:  d[{sub[3:2], 2'b00} +: 4] = din[3:0];
            3'b011:  if (sub[3]) res[17:9] = din[8:0];
                     else        res[8:0]  = din[8:0];
            default: res = din;
        endcase
        // Narrow modes edited the packed data view; scatter it back.
        if (width < 3'b011) begin
            res[16:9] = d[15:8];
            res[7:0]  = d[7:0];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------ write
    logic                w_we;
    logic [ROW_BITS-1:0] w_wr_row;

    assign w_we     = c_en && c_wen && (c_blk == 2'b11);
    assign w_wr_row = f_merge(r_mem[c_addr[9:4]], c_width, c_addr[3:0], c_din);

`ifdef RAM64X18_INIT_ZERO_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_ROWS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[c_addr[9:4]] <= w_wr_row;
        end
    end
`else
    // Reset held at the edge suppresses the write (a write in flight when
    // reset arrives is dropped), but the array itself is never cleared.
    always_ff @(posedge clock) begin
        if (w_we && reset_n) begin
            r_mem[c_addr[9:4]] <= w_wr_row;
        end
    end
`endif

    // ------------------------------------------------------------ read ports
    logic [9:0]          w_p_addr      [2];
    logic [1:0]          w_p_blk       [2];
    logic                w_p_en        [2];
    logic                w_p_addr_en   [2];
    logic                w_p_addr_lat  [2];
    logic                w_p_dout_en   [2];
    logic                w_p_dout_lat  [2];
    logic                w_p_dout_srst [2];
    logic [2:0]          w_p_width     [2];
    logic [ROW_BITS-1:0] w_p_dout      [2];

    assign w_p_addr[0]      = a_addr;        assign w_p_addr[1]      = b_addr;
    assign w_p_blk[0]       = a_blk;         assign w_p_blk[1]       = b_blk;
    assign w_p_en[0]        = a_en;          assign w_p_en[1]        = b_en;
    assign w_p_addr_en[0]   = a_addr_en;     assign w_p_addr_en[1]   = b_addr_en;
    assign w_p_addr_lat[0]  = a_addr_lat;    assign w_p_addr_lat[1]  = b_addr_lat;
    assign w_p_dout_en[0]   = a_dout_en;     assign w_p_dout_en[1]   = b_dout_en;
    assign w_p_dout_lat[0]  = a_dout_lat;    assign w_p_dout_lat[1]  = b_dout_lat;
    assign w_p_dout_srst[0] = a_dout_srst_n; assign w_p_dout_srst[1] = b_dout_srst_n;
    assign w_p_width[0]     = a_width;       assign w_p_width[1]     = b_width;

    assign a_dout = w_p_dout[0];
    assign b_dout = w_p_dout[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic [9:0]          r_addr;
        logic [ROW_BITS-1:0] r_dout;
        logic [9:0]          w_eff_addr;
        logic [ROW_BITS-1:0] w_rd;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_addr <= '0;
            end else if (w_p_addr_en[gi]) begin
                r_addr <= w_p_addr[gi];
            end
        end

        assign w_eff_addr = w_p_addr_lat[gi] ? w_p_addr[gi] : r_addr;
        assign w_rd = (w_p_en[gi] && (w_p_blk[gi] == 2'b11))
                    ? f_extract(r_mem[w_eff_addr[9:4]], w_p_width[gi], w_eff_addr[3:0])
                    : '0;

        // Synchronous clear wins over load.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_dout <= '0;
            end else if (!w_p_dout_srst[gi]) begin
                r_dout <= '0;
            end else if (w_p_dout_en[gi]) begin
                r_dout <= w_rd;
            end
        end

        // The bypass path is combinational from the array, so gate it with
        // reset to keep dout at zero for the whole reset interval.
        assign w_p_dout[gi] = !reset_n ? '0 : (w_p_dout_lat[gi] ? w_rd : r_dout);
    end

    assign busy = 1'b0;

endmodule

// File: tb/tb_ram64x18.sv
module tb_ram64x18;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  a_addr, b_addr, c_addr;
    logic [1:0]  a_blk, b_blk, c_blk;
    logic        a_en, a_addr_en, a_addr_lat, a_dout_en, a_dout_lat, a_dout_srst_n;
    logic        b_en, b_addr_en, b_addr_lat, b_dout_en, b_dout_lat, b_dout_srst_n;
    logic [2:0]  a_width, b_width, c_width;
    logic [17:0] a_dout, b_dout, c_din;
    logic        c_wen, c_en, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram64x18 dut (
        .clock(clock), .reset_n(reset_n),
        .a_addr(a_addr), .a_blk(a_blk), .a_en(a_en), .a_addr_en(a_addr_en),
        .a_addr_lat(a_addr_lat), .a_dout_en(a_dout_en), .a_dout_lat(a_dout_lat),
        .a_dout_srst_n(a_dout_srst_n), .a_width(a_width), .a_dout(a_dout),
        .b_addr(b_addr), .b_blk(b_blk), .b_en(b_en), .b_addr_en(b_addr_en),
        .b_addr_lat(b_addr_lat), .b_dout_en(b_dout_en), .b_dout_lat(b_dout_lat),
        .b_dout_srst_n(b_dout_srst_n), .b_width(b_width), .b_dout(b_dout),
        .c_addr(c_addr), .c_din(c_din), .c_wen(c_wen), .c_blk(c_blk),
        .c_en(c_en), .c_width(c_width), .busy(busy)
    );

    localparam logic [2:0] W1 = 3'd0, W2 = 3'd1, W4 = 3'd2, W9 = 3'd3, W18 = 3'd4;

    typedef struct {
        logic        wr;
        logic [9:0]  caddr;
        logic [2:0]  cw;
        logic [17:0] din;
        logic [9:0]  aaddr;
        logic [2:0]  aw;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", name, act, exp);
        end else begin
            $display("ok   %s: %05h", name, act);
        end
    endtask

    task automatic wr(input logic [9:0] addr, input logic [17:0] din, input logic [2:0] w,
                      input logic [1:0] blk, input logic wen);
        @(negedge clock);
        c_addr = addr; c_din = din; c_width = w; c_blk = blk; c_wen = wen; c_en = 1'b1;
        @(negedge clock);
        c_en = 1'b0; c_wen = 1'b0;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [17:0] exp_a, exp_b;

    initial begin
        reset_n = 1'b0;
        {a_addr, b_addr, c_addr, c_din} = '0;
        a_blk = 2'b11; b_blk = 2'b11; c_blk = 2'b11;
        a_en = 1'b1; b_en = 1'b1; c_en = 1'b0; c_wen = 1'b0;
        a_addr_en = 1'b0; b_addr_en = 1'b0;
        a_addr_lat = 1'b0; b_addr_lat = 1'b0;
        a_dout_en = 1'b0; b_dout_en = 1'b0;
        a_dout_lat = 1'b0; b_dout_lat = 1'b0;
        a_dout_srst_n = 1'b1; b_dout_srst_n = 1'b1;
        a_width = W18; b_width = W18; c_width = W18;

        // Reset state
        @(negedge clock); @(negedge clock);
        check("reset a_dout", a_dout, 18'h0);
        check("reset b_dout", b_dout, 18'h0);
        check("busy", {17'b0, busy}, 18'h0);
        reset_n = 1'b1;

        // Table: optional write, then combinational read on port A.
        //           wr    caddr    cw   din        aaddr    aw   exp
        vecs[0]  = '{1'b1, 10'h030, W18, 18'h3FFFF, 10'h030, W18, 18'h3FFFF};
        vecs[1]  = '{1'b1, 10'h038, W9,  18'h00000, 10'h030, W18, 18'h001FF};
        vecs[2]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h030, W1,  18'h00001};
        vecs[3]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h038, W9,  18'h00000};
        vecs[4]  = '{1'b1, 10'h040, W18, 18'h12345, 10'h040, W18, 18'h12345};
        vecs[5]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h048, W9,  18'h00091};
        vecs[6]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h040, W9,  18'h00145};
        vecs[7]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h040, W4,  18'h00005};
        vecs[8]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h04C, W4,  18'h00009};
        vecs[9]  = '{1'b0, 10'h000, W18, 18'h00000, 10'h046, W2,  18'h00001};
        vecs[10] = '{1'b0, 10'h000, W18, 18'h00000, 10'h04F, W1,  18'h00001};
        vecs[11] = '{1'b0, 10'h000, W18, 18'h00000, 10'h04E, W1,  18'h00000};
        vecs[12] = '{1'b1, 10'h04E, W1,  18'h00001, 10'h040, W18, 18'h1A345};
        vecs[13] = '{1'b1, 10'h044, W4,  18'h0000F, 10'h040, W18, 18'h1A3F5};
        vecs[14] = '{1'b1, 10'h048, W2,  18'h00000, 10'h040, W18, 18'h1A1F5};
        vecs[15] = '{1'b0, 10'h000, W18, 18'h00000, 10'h040, 3'd7, 18'h1A1F5};

        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            c_en = vecs[i].wr; c_wen = 1'b1; c_blk = 2'b11;
            c_addr = vecs[i].caddr; c_width = vecs[i].cw; c_din = vecs[i].din;
            a_addr_lat = 1'b1; a_dout_lat = 1'b1;
            a_addr = vecs[i].aaddr; a_width = vecs[i].aw;
            tick();
            check($sformatf("vec%0d", i), a_dout, vecs[i].exp);
        end
        @(negedge clock);
        c_en = 1'b0; c_wen = 1'b0;

        // x9 write, registered address, bypassed output
        wr(10'h028, 18'h000A5, W9, 2'b11, 1'b1);
        a_addr_lat = 1'b0; a_addr_en = 1'b1; a_dout_lat = 1'b1;
        a_addr = 10'h028; a_width = W9;
        tick();
        check("x9 regaddr read", a_dout, 18'h000A5);
        @(negedge clock);
        a_addr_en = 1'b0; a_addr = 10'h030;
        tick();
        check("addr reg hold", a_dout, 18'h000A5);

        // Registered output: two-cycle latency, sync clear, hold
        wr(10'h050, 18'h12345, W18, 2'b11, 1'b1);
        a_addr_lat = 1'b0; a_addr_en = 1'b1; a_addr = 10'h050; a_width = W18;
        a_dout_lat = 1'b0; a_dout_en = 1'b1; a_dout_srst_n = 1'b1;
        tick();
        tick();
        check("regout 2clk", a_dout, 18'h12345);
        @(negedge clock);
        a_dout_srst_n = 1'b0;
        tick();
        check("regout srst", a_dout, 18'h00000);
        @(negedge clock);
        a_dout_srst_n = 1'b1;
        tick();
        check("regout reload", a_dout, 18'h12345);
        @(negedge clock);
        a_dout_en = 1'b0; a_addr = 10'h030;
        tick();
        check("regout hold1", a_dout, 18'h12345);
        tick();
        check("regout hold2", a_dout, 18'h12345);
        @(negedge clock);
        a_dout_en = 1'b1;
        tick();
        check("regout new", a_dout, 18'h001FF);

        // Block/enable gating
        @(negedge clock);
        a_addr_lat = 1'b1; a_dout_lat = 1'b1; a_addr = 10'h050; a_blk = 2'b01;
        tick();
        check("a_blk=01", a_dout, 18'h0);
        @(negedge clock);
        a_blk = 2'b11; a_en = 1'b0;
        tick();
        check("a_en=0", a_dout, 18'h0);
        @(negedge clock);
        a_en = 1'b1;
        wr(10'h050, 18'h00000, W18, 2'b10, 1'b1);
        tick();
        check("c_blk=10 no write", a_dout, 18'h12345);
        wr(10'h050, 18'h00000, W18, 2'b11, 1'b0);
        tick();
        check("c_wen=0 no write", a_dout, 18'h12345);

        // Fill all 128 x9 words with their index
        for (int i = 0; i < 128; i++) begin
            wr(10'(i << 3), 18'(i), W9, 2'b11, 1'b1);
        end
        // Interleaved readback: A ascending, B descending, crossing 127<->0
        a_addr_lat = 1'b0; a_addr_en = 1'b1; a_dout_lat = 1'b1; a_width = W9;
        b_addr_lat = 1'b0; b_addr_en = 1'b1; b_dout_lat = 1'b1; b_width = W9;
        for (int i = 0; i < 130; i++) begin
            @(negedge clock);
            a_addr = 10'((i % 128) << 3);
            b_addr = 10'(((255 - i) % 128) << 3);
            tick();
            check($sformatf("wrap A[%0d]", i % 128), a_dout, 18'(i % 128));
            check($sformatf("wrap B[%0d]", (255 - i) % 128), b_dout, 18'((255 - i) % 128));
        end

        // Reset mid-operation with a write pending
        @(negedge clock);
        a_addr = 10'h050; b_addr = 10'h0A0;
        tick();
        check("pre-reset A", a_dout, 18'd10);
        check("pre-reset B", b_dout, 18'd20);
        c_addr = 10'h028; c_din = 18'h001FF; c_width = W9; c_blk = 2'b11;
        c_wen = 1'b1; c_en = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset async A", a_dout, 18'h0);
        check("reset async B", b_dout, 18'h0);
        @(posedge clock);
        @(negedge clock);
        c_en = 1'b0; c_wen = 1'b0;
        a_addr_en = 1'b0; b_addr_en = 1'b0; a_width = W18; b_width = W18;
        reset_n = 1'b1;
`ifdef RAM64X18_INIT_ZERO_EN
        exp_a = 18'h0; exp_b = 18'h0;
`else
        exp_a = 18'h00200; exp_b = 18'h00200;   // row 0 = {word1, word0}
`endif
        tick();
        check("addr reg cleared A", a_dout, exp_a);
        check("addr reg cleared B", b_dout, exp_b);
        @(negedge clock);
        a_addr_lat = 1'b1; a_addr = 10'h028; a_width = W9;
        b_addr_lat = 1'b1; b_addr = 10'h050; b_width = W9;
`ifdef RAM64X18_INIT_ZERO_EN
        exp_a = 18'h0; exp_b = 18'h0;
`else
        exp_a = 18'd5; exp_b = 18'd10;
`endif
        tick();
        check("aborted write word5", a_dout, exp_a);
        check("retained word10", b_dout, exp_b);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ram64x18.md
Name: ram64x18

Overview:
- Behavioural model of a 64x18-bit micro-SRAM (1152 bits) with two read ports (A, B) and one write port (C).
- Each port has a selectable aspect ratio; read address registers and output registers can each be bypassed.
- Serves as the storage primitive under the UART FIFO controller, which uses it in 128x8 mode: port A reads, port C writes, port B is unused.

Parameters:
- DEPTH_ROWS, 64, physical rows.
- ROW_BITS, 18, bits per physical row.

Ports:
- clock  in  1  single clock for all ports.
- reset_n  in  1  asynchronous active-low reset.
- a_addr  in  10  port A bit-granular address.
- a_blk  in  2  port A block selects; port enabled only when 2'b11.
- a_en  in  1  port A enable.
- a_addr_en  in  1  port A address-register load enable.
- a_addr_lat  in  1  1 = address register bypassed; 0 = registered.
- a_dout_en  in  1  port A output-register load enable.
- a_dout_lat  in  1  1 = output register bypassed; 0 = registered.
- a_dout_srst_n  in  1  port A output register synchronous clear, active-low.
- a_width  in  3  port A aspect ratio.
- a_dout  out  18  port A read data.
- b_*: identical set to a_*, with b_dout as its output.
- c_addr  in  10  write address.
- c_din  in  18  write data.
- c_wen  in  1  write enable, active-high.
- c_blk  in  2  write block selects; enabled only when 2'b11.
- c_en  in  1  write port enable.
- c_width  in  3  write aspect ratio.
- busy  out  1  always 0.

Behaviour:
- Width codes:
  - 000: x1, 1024 words.
  - 001: x2, 512 words.
  - 010: x4, 256 words.
  - 011: x9, 128 words.
  - 100: x18, 64 words.
  - 101-111: treated as 100.
- Row select = addr[9:4] in every mode.
- x18: whole row, addr[3:0] ignored.
- x9: addr[3]=0 selects row[8:0], addr[3]=1 selects row[17:9]; addr[2:0] ignored. An 8-bit user connects data [7:0] with addr[2:0]=0.
- x4/x2/x1: operate on the 16 "data" bits D = {row[16:9], row[7:0]}.
  - x4: nibble addr[3:2].
  - x2: pair addr[3:1].
  - x1: bit addr[3:0].
  - Data is right-justified on din/dout; unused dout bits read 0.
- Write: on posedge clock, when c_en & c_wen & (c_blk==2'b11), the selected field of the selected row is updated. All other bits are unchanged.
- Read address path:
  - a_addr_lat=0: address register loads a_addr on posedge when a_addr_en=1, and holds otherwise.
  - a_addr_lat=1: a_addr is used combinationally.
- Read data path:
  - Array output is combinational from the effective address.
  - a_dout_lat=1: a_dout = array output, 1 cycle after address capture.
  - a_dout_lat=0: output register loads on posedge when a_dout_en=1, giving 2 cycles of latency. It is cleared synchronously when a_dout_srst_n=0, with priority over the load.
- Port disabled (a_en=0 or a_blk!=2'b11): array output forced to 0.
- Read-during-write to the same location: the write takes effect at the edge. A registered-address, bypassed-output read then shows the new data in the following cycle.
- Port B behaves identically to port A and is fully independent of it.
- Reset (reset_n=0, asynchronous):
  - A/B address registers cleared to 0.
  - A/B output registers cleared to 0.
  - Memory contents unaffected, except as described under Optional Feature.
  - Reset asserted mid-write aborts that write.
- Reset values: a_dout = b_dout = 0 while in reset; busy = 0 always.

Optional Feature:
- Macro RAM64X18_INIT_ZERO_EN.
- Defined: reset_n=0 additionally clears all 64 rows to 0 asynchronously, so reads after reset return 0.
- Undefined: memory is not touched by reset; power-up contents are X in simulation.

Test Plan:
- x9 write/read. Write 0x0A5 at c_addr={7'd5,3'b0}, then read port A (addr_lat=0, dout_lat=1) at the same address -> a_dout[8:0]=0x0A5 one cycle after address capture; a_dout[17:9]=0.
- Mixed widths.
  - Write 0x3FFFF x18 at row 3, then write x9 0x000 at addr {6'd3,1'b1,3'b0}.
  - Read x18 at row 3 -> 0x001FF.
  - Read x1 at bit addr {6'd3,4'd0} -> 1.
- Registered output. With dout_lat=0, dout_en=1, read of stored 0x12345 -> a_dout=0x12345 after 2 clocks. Then dout_srst_n=0 for one clock -> a_dout=0.
- Block/enable gating. a_blk=2'b01 -> a_dout=0. A write with c_blk=2'b10 or c_wen=0 leaves memory unchanged on readback.
- Wrap/independence. Fill all 128 x9 words with their index, then read back interleaved on A (ascending) and B (descending) -> each port returns its own index, including 127->0 boundaries.
- Reset mid-operation. Assert reset_n=0 between clocks -> a_dout and b_dout = 0 immediately and address registers = 0. After release, data is still present; with RAM64X18_INIT_ZERO_EN defined, all reads return 0.
